seq_booth_multiplier: RTL



---
 rtl/mult_pkg.sv | 29 ++
 rtl/seq_booth_multiplier_booth_step.sv | 46 ++++
 rtl/seq_booth_multiplier.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // Counter must hold N+1 iterations.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/seq_booth_multiplier_booth_step.sv
// One combinational radix-2 Booth iteration: add/sub then arithmetic shift.
// With MULT_EARLY_TERM_EN the shift amount is variable (barrel shifter).
module booth_step
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic signed [N+1:0]         acc,
    input  logic        [N:0]           q,
    input  logic                        q_m1,
    input  logic signed [N:0]           a_ext,
`ifdef MULT_EARLY_TERM_EN
    input  logic [cnt_width(N)-1:0]     shamt,
`endif
    output logic signed [N+1:0]         acc_nxt,
    output logic        [N:0]           q_nxt,
    output logic                        q_m1_nxt
);

    booth_op_t           op;
    logic signed [N+1:0] a_wide;
    logic signed [N+1:0] sum;
    logic signed [2*N+3:0] full;
    logic signed [2*N+3:0] shifted;

    always_comb begin
        op     = booth_decode(q[0], q_m1);
        a_wide = {a_ext[N], a_ext};
        case (op)
            ADD:     sum = acc + a_wide;
            SUB:     sum = acc - a_wide;
            default: sum = acc;
        endcase
        // Shifting {acc, q, q_m1} as one word makes q_m1 pick up the last bit shifted out.
        full = {sum, q, q_m1};
`ifdef MULT_EARLY_TERM_EN
        shifted = full >>> shamt;
`else
        shifted = full >>> 1;
`endif
        acc_nxt  = shifted[2*N+3:N+2];
        q_nxt    = shifted[N+1:1];
        q_m1_nxt = shifted[0];
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, valid/ready on both sides, signed/unsigned per transaction.
// Define MULT_EARLY_TERM_EN to finish early once the remaining multiplier bits are uniform.
module seq_booth_multiplier
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int CW = cnt_width(N);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic signed [N:0]   a_ext;
    logic signed [N+1:0] acc;
    logic signed [N+1:0] acc_nxt;
    logic [N:0]          q;
    logic [N:0]          q_nxt;
    logic                q_m1;
    logic                q_m1_nxt;
    logic                accept;
    logic                finish;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

`ifdef MULT_EARLY_TERM_EN
    logic          all_same;
    logic [CW-1:0] shamt;

    // Unprocessed bits q[cnt-1:1] all matching q[0] means every later pair is a NOP.
    always_comb begin
        all_same = 1'b1;
        for (int i = 1; i <= N; i++) begin
            if (i < int'(cnt) && q[i] != q[0]) all_same = 1'b0;
        end
    end

    assign shamt  = all_same ? cnt : CW'(1);
    assign finish = all_same || (cnt == CW'(1));
`else
    assign finish = (cnt == CW'(1));
`endif

    booth_step #(
        .N(N)
    ) u_step (
        .acc      (acc),
        .q        (q),
        .q_m1     (q_m1),
        .a_ext    (a_ext),
`ifdef MULT_EARLY_TERM_EN
        .shamt    (shamt),
`endif
        .acc_nxt  (acc_nxt),
        .q_nxt    (q_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= BUSY;
                        cnt   <= CW'(N + 1);
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state   <= DONE;
                        cnt     <= '0;
                        product <= {acc_nxt[N-2:0], q_nxt};
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (accept) begin
                        state <= BUSY;
                        cnt   <= CW'(N + 1);
                    end else if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_ext <= {a[N-1] & signed_mode, a};
            acc   <= '0;
            q     <= {b[N-1] & signed_mode, b};
            q_m1  <= 1'b0;
        end else if (state == BUSY) begin
            acc  <= acc_nxt;
            q    <= q_nxt;
            q_m1 <= q_m1_nxt;
        end
    end

endmodule
